rx_unit: RTL and testbench

Receive-side serial front end of the CPU's memory interface. Watches `rx_pins`, frames each response (start, SBS, payload), and drives the RX handshake consumed by the prefetcher: `rx_started`, `rx_active`, `rx_sbs`/`rx_sbs_valid`, `rx_data_valid`, `rx_counter` and `rx_done`. Keeps a FIFO of 1-bit tags pushed by the TX side, so that prefetch read data is steered to the prefetcher and all other read data goes to the load path.

---
 rtl/rx_unit_pkg.sv | 19 +
 rtl/rx_tag_fifo.sv | 62 ++++++
 rtl/rx_unit.sv | 131 +++++++++++++
 tb/tb_rx_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rx_unit_pkg.sv
// rx_unit_pkg: shared state encoding and SBS symbol values for the receive front end.
// Rev 1.0
`default_nettype none

package rx_unit_pkg;

  typedef enum logic [1:0] {
    RX_STATE_IDLE = 2'd0,
    RX_STATE_SBS  = 2'd1,
    RX_STATE_DATA = 2'd2
  } rx_state_e;

  // Value of rx_pins[0] in the SBS cycle: payload follows, or bare acknowledge.
  localparam logic RX_SBS_DATA = 1'b0;
  localparam logic RX_SBS_ACK  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rx_tag_fifo.sv
// rx_tag_fifo: 1-bit tag FIFO recording whether each outstanding request was a prefetch.
// Rev 1.0
`default_nettype none

module rx_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic empty,
  output logic full,
  output logic overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign overflow = push && full && !pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rx_unit.sv
// rx_unit: frames serial read responses and steers payload to prefetcher or load path.
// Rev 1.0
`default_nettype none

module rx_unit
  import rx_unit_pkg::*;
#(
  parameter int IO_BITS         = 2,
  parameter int PAYLOAD_CYCLES  = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [IO_BITS-1:0]                  rx_pins,
  input  logic                                tx_done,
  input  logic                                tx_is_prefetch,
  output logic                                rx_started,
  output logic                                rx_active,
  output logic [IO_BITS-1:0]                  rx_sbs,
  output logic                                rx_sbs_valid,
  output logic [$clog2(PAYLOAD_CYCLES):0]     rx_counter,
  output logic                                rx_data_valid,
  output logic                                rx_done,
  output logic                                rx_ld_data_valid,
  output logic                                rx_ld_done,
  output logic                                rx_error
);

  localparam int CNT_W = $clog2(PAYLOAD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_CYCLES - 1);

  rx_state_e        state;
  rx_state_e        state_next;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_next;
  logic             error;
  logic             pop;
  logic             start_err;
  logic             data_beat;
  logic             last_beat;
  logic             fifo_head;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_overflow;

  rx_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (tx_done),
    .din      (tx_is_prefetch),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (fifo_overflow)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RX_STATE_IDLE;
      counter <= '0;
      error   <= 1'b0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      error   <= error | start_err | fifo_overflow;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    pop          = 1'b0;
    start_err    = 1'b0;
    rx_started   = 1'b0;
    data_beat    = 1'b0;
    last_beat    = 1'b0;
    unique case (state)
      RX_STATE_IDLE: begin
        // A start bit with nothing outstanding cannot be attributed to any request.
        if (rx_pins[0]) begin
          if (!fifo_empty) begin
            rx_started = 1'b1;
            state_next = RX_STATE_SBS;
          end else begin
            start_err = 1'b1;
          end
        end
      end
      RX_STATE_SBS: begin
        counter_next = '0;
        if (rx_pins[0] == RX_SBS_DATA) begin
          state_next = RX_STATE_DATA;
        end else begin
          pop        = 1'b1;
          state_next = RX_STATE_IDLE;
        end
      end
      RX_STATE_DATA: begin
        data_beat = 1'b1;
        if (counter == CNT_LAST) begin
          last_beat    = 1'b1;
          pop          = 1'b1;
          counter_next = '0;
          state_next   = RX_STATE_IDLE;
        end else begin
          counter_next = counter + 1'b1;
        end
      end
      default: begin
        state_next   = RX_STATE_IDLE;
        counter_next = '0;
      end
    endcase
  end

  assign rx_active        = (state != RX_STATE_IDLE);
  assign rx_sbs_valid     = (state == RX_STATE_SBS);
  assign rx_sbs           = rx_sbs_valid ? rx_pins : '0;
  assign rx_counter       = counter;
  assign rx_data_valid    = data_beat && fifo_head;
  assign rx_ld_data_valid = data_beat && !fifo_head;
  assign rx_done          = last_beat && fifo_head;
  assign rx_ld_done       = last_beat && !fifo_head;
  assign rx_error         = error;

endmodule

`default_nettype wire

// File: tb/tb_rx_unit.sv
// tb_rx_unit: directed and randomized frame-level checks of rx_unit against a tag-queue model.
// Rev 1.0
`default_nettype none

module tb_rx_unit;

  localparam int IO = 2;
  localparam int P  = 8;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [IO-1:0] rx_pins = '0;
  logic          tx_done = 1'b0;
  logic          tx_is_prefetch = 1'b0;
  logic          rx_started;
  logic          rx_active;
  logic [IO-1:0] rx_sbs;
  logic          rx_sbs_valid;
  logic [3:0]    rx_counter;
  logic          rx_data_valid;
  logic          rx_done;
  logic          rx_ld_data_valid;
  logic          rx_ld_done;
  logic          rx_error;

  int errors = 0;
  int checks = 0;
  bit q[$];
  bit exp_err = 1'b0;

  rx_unit #(
    .IO_BITS         (IO),
    .PAYLOAD_CYCLES  (P),
    .MAX_OUTSTANDING (D)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .rx_pins          (rx_pins),
    .tx_done          (tx_done),
    .tx_is_prefetch   (tx_is_prefetch),
    .rx_started       (rx_started),
    .rx_active        (rx_active),
    .rx_sbs           (rx_sbs),
    .rx_sbs_valid     (rx_sbs_valid),
    .rx_counter       (rx_counter),
    .rx_data_valid    (rx_data_valid),
    .rx_done          (rx_done),
    .rx_ld_data_valid (rx_ld_data_valid),
    .rx_ld_done       (rx_ld_done),
    .rx_error         (rx_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check shortly after, then advance the model.
  task automatic step(input logic [1:0] pins, input bit push, input bit pval,
                      input bit e_start, input bit e_act, input bit e_sbsv,
                      input bit e_dv, input bit e_done, input bit e_ldv, input bit e_ldd,
                      input int e_cnt, input bit pop, input bit start_err);
    bit full_before;
    @(negedge clk);
    rx_pins = pins;
    tx_done = push;
    tx_is_prefetch = pval;
    #1;
    chk("flags", {rx_started, rx_active, rx_sbs_valid, rx_data_valid, rx_done,
                  rx_ld_data_valid, rx_ld_done},
                 {e_start, e_act, e_sbsv, e_dv, e_done, e_ldv, e_ldd});
    chk("sbs", rx_sbs, e_sbsv ? pins : 2'b00);
    chk("counter", rx_counter, e_cnt);
    chk("error", rx_error, exp_err);
    chk("fifo_cnt", dut.u_fifo.count, q.size());
    full_before = (q.size() == D);
    if (pop) void'(q.pop_front());
    if (push) begin
      if (full_before && !pop) exp_err = 1'b1;
      else q.push_back(pval);
    end
    if (start_err) exp_err = 1'b1;
  endtask

  task automatic idle(input logic [1:0] pins, input bit push, input bit pval);
    step(pins, push, pval, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0,
         pins[0] && (q.size() == 0));
  endtask

  task automatic do_reset(input logic [1:0] pins);
    @(negedge clk);
    rx_pins = pins;
    tx_done = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_flags", {rx_started, rx_active, rx_sbs_valid, rx_data_valid, rx_done,
                      rx_ld_data_valid, rx_ld_done}, 0);
    chk("rst_sbs", rx_sbs, 0);
    chk("rst_counter", rx_counter, 0);
    chk("rst_error", rx_error, 0);
    chk("rst_fifo", dut.u_fifo.count, 0);
    q.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rx_pins = '0;
    reset_n = 1'b1;
  endtask

  // Whole response frame; the consumer rebuilds the word from symbols LSB first.
  task automatic send_frame(input bit ack, input logic [15:0] payload,
                            input bit push_last, input bit pval_last, input int abort_at);
    bit h;
    bit last;
    logic [15:0] got;
    logic [1:0] sym;
    h = q[0];
    step({1'($urandom), 1'b1}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         0, 1'b0, 1'b0);
    if (ack) begin
      step({1'($urandom), 1'b1}, push_last, pval_last, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
           1'b0, 1'b0, 0, 1'b1, 1'b0);
    end else begin
      step({1'($urandom), 1'b0}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
           0, 1'b0, 1'b0);
      got = '0;
      for (int i = 0; i < P; i++) begin
        sym = payload[2*i +: 2];
        if (i == abort_at) begin
          do_reset(sym);
          return;
        end
        last = (i == P - 1);
        step(sym, last && push_last, pval_last, 1'b0, 1'b1, 1'b0, h, last && h, !h,
             last && !h, i, last, 1'b0);
        if (rx_data_valid || rx_ld_data_valid) got = {rx_pins, got[15:2]};
      end
      chk("payload", got, payload);
    end
  endtask

  initial begin
    int n;
    do_reset(2'b00);
    idle(2'b00, 1'b0, 1'b0);

    // single prefetch data frame, tag pushed the cycle before the start bit
    idle(2'b00, 1'b1, 1'b1);
    send_frame(1'b0, 16'h1234, 1'b0, 1'b0, -1);
    idle(2'b00, 1'b0, 1'b0);

    // prefetch then load frame, one idle cycle apart
    idle(2'b00, 1'b1, 1'b1);
    idle(2'b00, 1'b1, 1'b0);
    send_frame(1'b0, 16'($urandom), 1'b0, 1'b0, -1);
    idle(2'b00, 1'b0, 1'b0);
    send_frame(1'b0, 16'($urandom), 1'b0, 1'b0, -1);
    idle(2'b00, 1'b0, 1'b0);

    // ACK frame, then a start bit with nothing outstanding
    idle(2'b00, 1'b1, 1'b1);
    send_frame(1'b1, 16'h0000, 1'b0, 1'b0, -1);
    idle(2'b01, 1'b0, 1'b0);
    idle(2'b00, 1'b0, 1'b0);

    // start bit on empty FIFO right after reset
    do_reset(2'b00);
    idle(2'b01, 1'b0, 1'b0);
    idle(2'b11, 1'b0, 1'b0);
    idle(2'b00, 1'b0, 1'b0);

    // full FIFO: push alongside the final pop is kept, push while full is dropped
    do_reset(2'b00);
    idle(2'b00, 1'b1, 1'b1);
    idle(2'b00, 1'b1, 1'b0);
    send_frame(1'b0, 16'($urandom), 1'b1, 1'b1, -1);
    idle(2'b00, 1'b0, 1'b0);
    idle(2'b00, 1'b1, 1'b0);
    idle(2'b00, 1'b0, 1'b0);
    send_frame(1'b0, 16'($urandom), 1'b0, 1'b0, -1);
    idle(2'b00, 1'b0, 1'b0);
    send_frame(1'b0, 16'($urandom), 1'b0, 1'b0, -1);
    idle(2'b00, 1'b0, 1'b0);

    // reset in the middle of the payload, then a clean frame
    do_reset(2'b00);
    idle(2'b00, 1'b1, 1'b1);
    send_frame(1'b0, 16'hBEEF, 1'b0, 1'b0, 3);
    idle(2'b00, 1'b0, 1'b0);
    idle(2'b00, 1'b1, 1'b0);
    send_frame(1'b0, 16'hA5C3, 1'b0, 1'b0, -1);
    idle(2'b00, 1'b0, 1'b0);

    // randomized traffic
    do_reset(2'b00);
    for (int f = 0; f < 24; f++) begin
      n = (q.size() == 0) ? 1 : $urandom_range(0, D - q.size());
      for (int k = 0; k < n; k++) idle({1'($urandom), 1'b0}, 1'b1, 1'($urandom));
      send_frame(($urandom_range(0, 3) == 0), 16'($urandom),
                 (q.size() == D) ? 1'($urandom) : 1'b0, 1'($urandom), -1);
      idle({1'($urandom), 1'b0}, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
